grid_paint_ctrl: RTL

- Controller for the 3x3 colour-grid VGA datapath: owns the 9-entry RGB cell memory, the cursor position and the per-pixel colour selection.
- Takes raw switch/button levels, conditions them, and sequences paint/clear operations into the cell memory.
- Drives the 3-bit pixel bus from CounterX/CounterY/inDisplayArea supplied by hvsync_generator.
- Sits between the switch inputs, hvsync_generator and the VGA pixel output, clocked by the 25 MHz pixel clock.

---
 rtl/grid_pkg.sv | 19 +
 rtl/grid_paint_ctrl_btn_conditioner.sv | 47 ++++
 rtl/grid_paint_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared definitions for the 3x3 colour-grid controller.
//   NUM_CELLS / CELL_W : cell count and cell-index width
//   RGB_W, R/G/B       : pixel bus width and bit positions
//   state_t            : controller sequencing states
package grid_pkg;
    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned CELL_W    = 4;
    localparam int unsigned RGB_W     = 3;

    localparam int unsigned R = 0;
    localparam int unsigned G = 1;
    localparam int unsigned B = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        CLEAR = 2'd2
    } state_t;
endpackage

// File: rtl/grid_paint_ctrl_btn_conditioner.sv
// Raw button conditioning: 2-FF synchroniser, debounce, rising-edge pulse.
//   clk, rst_n : pixel clock, async active-low reset
//   i_btn      : raw active-high button level
//   o_pulse    : one-cycle pulse on each accepted 0->1 transition
module btn_conditioner #(
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int unsigned    CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    // Level flips on the DEB_CYCLES-th consecutive differing sample; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_pulse <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pulse = r_pulse;
endmodule

// File: rtl/grid_paint_ctrl.sv
// 3x3 colour-grid controller: cell memory, cursor, paint/clear sequencing, pixel mux.
//   clk, rst_n               : 25 MHz pixel clock, async active-low reset
//   btn_next/prev/paint/clear: raw active-high buttons
//   colour_sel               : {b,g,r} paint colour
//   counter_x/y, in_display  : raster position from hvsync_generator
//   pixel                    : registered {b,g,r}, 1-cycle latency
//   cursor_pos               : current cursor cell 0..8
//   busy                     : high during the 9-cycle clear sweep
module grid_paint_ctrl
    import grid_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned DEB_CYCLES   = 250000,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned BORDER       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_paint,
    input  logic              btn_clear,
    input  logic [RGB_W-1:0]  colour_sel,
    input  logic [9:0]        counter_x,
    input  logic [9:0]        counter_y,
    input  logic              in_display,
    output logic [RGB_W-1:0]  pixel,
    output logic [CELL_W-1:0] cursor_pos,
    output logic              busy
);
    localparam logic [9:0] X1  = 10'(H_ACTIVE / 3);
    localparam logic [9:0] X2  = 10'(2 * H_ACTIVE / 3);
    localparam logic [9:0] XE  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y1  = 10'(V_ACTIVE / 3);
    localparam logic [9:0] Y2  = 10'(2 * V_ACTIVE / 3);
    localparam logic [9:0] YE  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] BRD = 10'(BORDER);

    localparam int unsigned       FR_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0]   FR_LAST = FR_W'(BLINK_FRAMES - 1);
    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(NUM_CELLS - 1);

    logic w_ev_next, w_ev_prev, w_ev_paint, w_ev_clear;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_next  (.clk(clk), .rst_n(rst_n), .i_btn(btn_next),  .o_pulse(w_ev_next));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_prev  (.clk(clk), .rst_n(rst_n), .i_btn(btn_prev),  .o_pulse(w_ev_prev));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_paint (.clk(clk), .rst_n(rst_n), .i_btn(btn_paint), .o_pulse(w_ev_paint));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clear (.clk(clk), .rst_n(rst_n), .i_btn(btn_clear), .o_pulse(w_ev_clear));

    state_t              r_state, w_state_nx;
    logic [CELL_W-1:0]   r_cursor, w_cursor_nx;
    logic [CELL_W-1:0]   r_clr_idx, w_clr_idx_nx;
    logic                r_busy, w_busy_nx;
    logic [RGB_W-1:0]    r_cells [NUM_CELLS];
    logic [RGB_W-1:0]    r_pixel;
    logic [FR_W-1:0]     r_frame;
    logic                r_blink;

    logic                w_we;
    logic [CELL_W-1:0]   w_waddr;
    logic [RGB_W-1:0]    w_wdata;

    // Next-state, cursor and cell write port; events only act in IDLE, highest priority wins.
    always_comb begin
        w_state_nx   = r_state;
        w_cursor_nx  = r_cursor;
        w_clr_idx_nx = r_clr_idx;
        w_busy_nx    = r_busy;
        w_we         = 1'b0;
        w_waddr      = r_cursor;
        w_wdata      = colour_sel;
        unique case (r_state)
            IDLE: begin
                if (w_ev_clear) begin
                    w_state_nx   = CLEAR;
                    w_clr_idx_nx = '0;
                    w_busy_nx    = 1'b1;
                end else if (w_ev_paint) begin
                    w_state_nx = PAINT;
                end else if (w_ev_next) begin
                    w_cursor_nx = (r_cursor == LAST_CELL) ? '0 : r_cursor + CELL_W'(1);
                end else if (w_ev_prev) begin
                    w_cursor_nx = (r_cursor == '0) ? LAST_CELL : r_cursor - CELL_W'(1);
                end
            end
            PAINT: begin
                w_we       = 1'b1;
                w_state_nx = IDLE;
            end
            CLEAR: begin
                w_we         = 1'b1;
                w_waddr      = r_clr_idx;
                w_wdata      = '0;
                w_clr_idx_nx = r_clr_idx + CELL_W'(1);
                if (r_clr_idx == LAST_CELL) begin
                    w_state_nx = IDLE;
                    w_busy_nx  = 1'b0;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Controller state and cell memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cursor  <= '0;
            r_clr_idx <= '0;
            r_busy    <= 1'b0;
            r_cells   <= '{default: '0};
        end else begin
            r_state   <= w_state_nx;
            r_cursor  <= w_cursor_nx;
            r_clr_idx <= w_clr_idx_nx;
            r_busy    <= w_busy_nx;
            if (w_we) begin
                r_cells[w_waddr] <= w_wdata;
            end
        end
    end

    // Frame counter and blink phase, advanced once per frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
            r_blink <= 1'b0;
        end else if (counter_x == '0 && counter_y == '0) begin
            if (r_frame == FR_LAST) begin
                r_frame <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_frame <= r_frame + FR_W'(1);
            end
        end
    end

    logic [1:0]        w_col, w_row;
    logic [9:0]        w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    logic              w_border;
    logic [CELL_W-1:0] w_cell;
    logic [RGB_W-1:0]  w_hl;
    logic [RGB_W-1:0]  w_pixel_nx;

    // Cell decode with the cell's own bounds, so the border test is a distance to either edge.
    always_comb begin
        w_col  = 2'd2;
        w_x_lo = X2;
        w_x_hi = XE;
        if (counter_x < X1) begin
            w_col  = 2'd0;
            w_x_lo = '0;
            w_x_hi = X1 - 10'd1;
        end else if (counter_x < X2) begin
            w_col  = 2'd1;
            w_x_lo = X1;
            w_x_hi = X2 - 10'd1;
        end
        w_row  = 2'd2;
        w_y_lo = Y2;
        w_y_hi = YE;
        if (counter_y < Y1) begin
            w_row  = 2'd0;
            w_y_lo = '0;
            w_y_hi = Y1 - 10'd1;
        end else if (counter_y < Y2) begin
            w_row  = 2'd1;
            w_y_lo = Y1;
            w_y_hi = Y2 - 10'd1;
        end
        w_border = ((counter_x - w_x_lo) < BRD) || ((w_x_hi - counter_x) < BRD) ||
                   ((counter_y - w_y_lo) < BRD) || ((w_y_hi - counter_y) < BRD);
        w_cell   = ({2'b00, w_row} * 4'd3) + {2'b00, w_col};

        w_hl    = '0;
        w_hl[R] = 1'b1;
        w_hl[G] = 1'b1;
        w_hl[B] = 1'b1;

        if (!in_display) begin
            w_pixel_nx = '0;
        end else if (w_cell == r_cursor && w_border && r_blink) begin
            w_pixel_nx = w_hl;
        end else begin
            w_pixel_nx = r_cells[w_cell];
        end
    end

    // Registered pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel <= '0;
        end else begin
            r_pixel <= w_pixel_nx;
        end
    end

    assign pixel      = r_pixel;
    assign cursor_pos = r_cursor;
    assign busy       = r_busy;
endmodule
